// File: rtl/game_board_if.sv
// Move handshake and board-state bus between the move-entry front end and game_board.
// The master offers moves; the slave (game_board) returns pulses, turn and board state.
interface game_board_if #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int PLAYERS = 2
);
  localparam int N      = ROWS * COLS;
  localparam int LOC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CELL_W = $clog2(PLAYERS + 1);
  localparam int PW     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  logic                   move_valid;
  logic                   move_ready;
  logic [LOC_W-1:0]       move_loc;
  logic                   move_accept;
  logic                   move_reject;
  logic [PW-1:0]          turn;
  logic [N*CELL_W-1:0]    board;
  logic [CNT_W-1:0]       move_count;
  logic [CELL_W-1:0]      winner;
  logic                   draw;
  logic                   game_over;

  modport master (
    output move_valid, move_loc,
    input  move_ready, move_accept, move_reject, turn, board,
           move_count, winner, draw, game_over
  );

  modport slave (
    input  move_valid, move_loc,
    output move_ready, move_accept, move_reject, turn, board,
           move_count, winner, draw, game_over
  );
endinterface

// File: rtl/game_board.sv
// ROWS x COLS board for PLAYERS players: validates a move in one cycle, then scans one direction
// per cycle (4 cycles) through the placed cell; move_ready is low until the scan finishes.
module game_board #(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int PLAYERS = 2,
  parameter int WIN_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  game_board_if.slave  bus
);
  localparam int N      = ROWS * COLS;
  localparam int LOC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CELL_W = $clog2(PLAYERS + 1);
  localparam int PW     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_e;
  typedef logic [CELL_W-1:0] cell_t;

  state_e           state_q, state_d;
  cell_t            board_q [N];
  cell_t            board_d [N];
  logic [PW-1:0]    turn_q, turn_d;
  logic [PW-1:0]    first_q, first_d;
  logic [PW-1:0]    mover_q, mover_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cell_t            winner_q, winner_d;
  logic             draw_q, draw_d;
  logic             over_q, over_d;
  logic             accept_q, accept_d;
  logic             reject_q, reject_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  logic [1:0]       dir_q, dir_d;
  logic             legal;
  logic             win;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (32'(p) == PLAYERS - 1) ? '0 : p + PW'(1);
  endfunction

  function automatic logic cell_is(input cell_t b [N], input int unsigned idx, input cell_t who);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(i) == idx && b[i] == who) hit = 1'b1;
    end
    return hit;
  endfunction

  // Out-of-range locations match no cell, so they can never alias onto the board.
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(bus.move_loc) == 32'(i) && board_q[i] == '0) legal = 1'b1;
    end
  end

  // Run length through the latched cell along dir_q; each side walks at most WIN_LEN-1 steps.
  always_comb begin
    int unsigned row, col, r, c, run;
    logic        ok, go_f, go_b, dr, dc_pos, dc_neg;
    cell_t       mover_cell;
    row        = 32'(loc_q) / COLS;
    col        = 32'(loc_q) % COLS;
    dr         = (dir_q != 2'd0);
    dc_pos     = (dir_q == 2'd0) || (dir_q == 2'd2);
    dc_neg     = (dir_q == 2'd3);
    mover_cell = CELL_W'(mover_q) + CELL_W'(1);
    run        = 1;
    go_f       = 1'b1;
    go_b       = 1'b1;
    for (int unsigned k = 1; k < WIN_LEN; k++) begin
      r  = dr ? row + k : row;
      ok = go_f && (r < ROWS);
      if (dc_pos) begin
        c  = col + k;
        ok = ok && (c < COLS);
      end else if (dc_neg) begin
        c  = col - k;
        ok = ok && (col >= k);
      end else begin
        c = col;
      end
      go_f = ok && cell_is(board_q, r * COLS + c, mover_cell);
      if (go_f) run++;

      r  = dr ? row - k : row;
      ok = go_b && (!dr || row >= k);
      if (dc_pos) begin
        c  = col - k;
        ok = ok && (col >= k);
      end else if (dc_neg) begin
        c  = col + k;
        ok = ok && (c < COLS);
      end else begin
        c = col;
      end
      go_b = ok && cell_is(board_q, r * COLS + c, mover_cell);
      if (go_b) run++;
    end
    win = (state_q == CHECK) && (run >= WIN_LEN);
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    first_d  = first_q;
    mover_d  = mover_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    over_d   = over_q;
    loc_d    = loc_q;
    dir_d    = dir_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    if (clear) begin
      board_d  = '{default: '0};
      cnt_d    = '0;
      winner_d = '0;
      draw_d   = 1'b0;
      over_d   = 1'b0;
      dir_d    = '0;
      state_d  = IDLE;
      first_d  = next_player(first_q);
      turn_d   = first_d;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.move_valid) begin
            if (legal) begin
              for (int i = 0; i < N; i++) begin
                if (32'(bus.move_loc) == 32'(i)) board_d[i] = CELL_W'(turn_q) + CELL_W'(1);
              end
              cnt_d    = cnt_q + CNT_W'(1);
              accept_d = 1'b1;
              loc_d    = bus.move_loc;
              mover_d  = turn_q;
              dir_d    = '0;
              state_d  = CHECK;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (win) begin
            winner_d = CELL_W'(mover_q) + CELL_W'(1);
            over_d   = 1'b1;
            state_d  = OVER;
          end else if (dir_q == 2'd3) begin
            if (32'(cnt_q) == N) begin
              draw_d  = 1'b1;
              over_d  = 1'b1;
              state_d = OVER;
            end else begin
              turn_d  = next_player(turn_q);
              state_d = IDLE;
            end
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      board_q  <= '{default: '0};
      turn_q   <= '0;
      first_q  <= '0;
      mover_q  <= '0;
      cnt_q    <= '0;
      winner_q <= '0;
      draw_q   <= 1'b0;
      over_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      loc_q    <= '0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      first_q  <= first_d;
      mover_q  <= mover_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      over_q   <= over_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      loc_q    <= loc_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.move_ready  = (state_q == IDLE);
  assign bus.move_accept = accept_q;
  assign bus.move_reject = reject_q;
  assign bus.turn        = turn_q;
  assign bus.move_count  = cnt_q;
  assign bus.winner      = winner_q;
  assign bus.draw        = draw_q;
  assign bus.game_over   = over_q;

  for (genvar g = 0; g < N; g++) begin : g_board
    assign bus.board[g*CELL_W +: CELL_W] = board_q[g];
  end
endmodule

// File: tb/tb_game_board.sv
// Bench for game_board: a 3x3/2-player instance and a 4x5/3-player/WIN_LEN=4 instance,
// each checked against a line-window reference model of the game.
module tb_game_board;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;
  always #5 clk = ~clk;

  game_board_if #(.ROWS(3), .COLS(3), .PLAYERS(2)) bus0 ();
  game_board_if #(.ROWS(4), .COLS(5), .PLAYERS(3)) bus1 ();

  game_board #(.ROWS(3), .COLS(3), .PLAYERS(2), .WIN_LEN(3)) dut0 (
    .clk(clk), .reset(rst), .clear(clr0), .bus(bus0));
  game_board #(.ROWS(4), .COLS(5), .PLAYERS(3), .WIN_LEN(4)) dut1 (
    .clk(clk), .reset(rst), .clear(clr1), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  int mb [2][20];
  int mturn [2];
  int mfirst [2];
  int mcnt [2];
  int mwin [2];
  bit mdraw [2];
  bit mover [2];

  logic [63:0] o_board;
  logic [7:0]  o_turn, o_cnt, o_win;
  logic        o_draw, o_over, o_rdy, o_acc, o_rej;

  function automatic int p_rows(int id); return (id == 0) ? 3 : 4; endfunction
  function automatic int p_cols(int id); return (id == 0) ? 3 : 5; endfunction
  function automatic int p_pl(int id);   return (id == 0) ? 2 : 3; endfunction
  function automatic int p_wl(int id);   return (id == 0) ? 3 : 4; endfunction

  function automatic logic [63:0] exp_board(int id);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < p_rows(id) * p_cols(id); i++) b |= 64'(mb[id][i]) << (2 * i);
    return b;
  endfunction

  // First direction (0 horiz, 1 vert, 2 diag, 3 anti) with a full WIN_LEN window through loc.
  function automatic int win_dir(int id, int loc, int who);
    int dr [4];
    int dc [4];
    int R, C, W, r0, c0, r, c;
    bit ok;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    R = p_rows(id); C = p_cols(id); W = p_wl(id);
    r0 = loc / C; c0 = loc % C;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < W; s++) begin
        ok = 1'b1;
        for (int j = 0; j < W; j++) begin
          r = r0 + (j - s) * dr[d];
          c = c0 + (j - s) * dc[d];
          if (r < 0 || r >= R || c < 0 || c >= C) ok = 1'b0;
          else if (mb[id][r * C + c] != who + 1) ok = 1'b0;
        end
        if (ok) return d;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset(int id);
    for (int i = 0; i < 20; i++) mb[id][i] = 0;
    mturn[id] = 0; mfirst[id] = 0; mcnt[id] = 0; mwin[id] = 0;
    mdraw[id] = 1'b0; mover[id] = 1'b0;
  endfunction

  task automatic set_mv(input int id, input logic v, input int loc);
    if (id == 0) begin bus0.move_valid = v; bus0.move_loc = 4'(loc); end
    else begin bus1.move_valid = v; bus1.move_loc = 5'(loc); end
  endtask

  task automatic set_clr(input int id, input logic v);
    if (id == 0) clr0 = v; else clr1 = v;
  endtask

  task automatic snap(input int id);
    if (id == 0) begin
      o_board = 64'(bus0.board); o_turn = 8'(bus0.turn); o_cnt = 8'(bus0.move_count);
      o_win = 8'(bus0.winner); o_draw = bus0.draw; o_over = bus0.game_over;
      o_rdy = bus0.move_ready; o_acc = bus0.move_accept; o_rej = bus0.move_reject;
    end else begin
      o_board = 64'(bus1.board); o_turn = 8'(bus1.turn); o_cnt = 8'(bus1.move_count);
      o_win = 8'(bus1.winner); o_draw = bus1.draw; o_over = bus1.game_over;
      o_rdy = bus1.move_ready; o_acc = bus1.move_accept; o_rej = bus1.move_reject;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; set_mv(0, 1'b1, 1); set_mv(1, 1'b1, 1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; set_mv(0, 1'b0, 0); set_mv(1, 1'b0, 0);
    for (int id = 0; id < 2; id++) begin
      model_reset(id);
      snap(id);
      n_cmp++; if (o_board !== 64'd0) begin n_err++; $display("FAIL reset_board id%0d: got %h want 0", id, o_board); end
      n_cmp++; if (o_turn !== 8'd0) begin n_err++; $display("FAIL reset_turn id%0d: got %0d want 0", id, o_turn); end
      n_cmp++; if (o_cnt !== 8'd0) begin n_err++; $display("FAIL reset_count id%0d: got %0d want 0", id, o_cnt); end
      n_cmp++; if ({o_win, o_draw, o_over} !== 10'd0) begin n_err++; $display("FAIL reset_flags id%0d: got win=%0d draw=%0b over=%0b want 0", id, o_win, o_draw, o_over); end
      n_cmp++; if ({o_rdy, o_acc, o_rej} !== 3'b100) begin n_err++; $display("FAIL reset_hs id%0d: got rdy/acc/rej=%b want 100", id, {o_rdy, o_acc, o_rej}); end
    end
  endtask

  task automatic do_move(input int id, input int loc);
    int n, wd, endk;
    bit live, legal;
    n = p_rows(id) * p_cols(id);
    live = !mover[id];
    legal = live && loc < n && mb[id][loc] == 0;
    @(negedge clk); set_mv(id, 1'b1, loc);
    @(posedge clk); @(negedge clk); set_mv(id, 1'b0, 0);
    snap(id);
    n_cmp++; if (o_acc !== legal) begin n_err++; $display("FAIL accept id%0d loc%0d: got %b want %b", id, loc, o_acc, legal); end
    n_cmp++; if (o_rej !== (live && !legal)) begin n_err++; $display("FAIL reject id%0d loc%0d: got %b want %b", id, loc, o_rej, live && !legal); end
    if (!legal) begin
      n_cmp++; if (o_board !== exp_board(id)) begin n_err++; $display("FAIL board_kept id%0d: got %h want %h", id, o_board, exp_board(id)); end
      n_cmp++; if (o_turn !== 8'(mturn[id])) begin n_err++; $display("FAIL turn_kept id%0d: got %0d want %0d", id, o_turn, mturn[id]); end
      n_cmp++; if (o_rdy !== live) begin n_err++; $display("FAIL ready_kept id%0d: got %b want %b", id, o_rdy, live); end
      return;
    end
    n_cmp++; if (o_rdy !== 1'b0) begin n_err++; $display("FAIL ready_busy id%0d: got %b want 0", id, o_rdy); end
    mb[id][loc] = mturn[id] + 1;
    mcnt[id]++;
    wd = win_dir(id, loc, mturn[id]);
    endk = (wd >= 0) ? wd + 1 : 4;
    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      snap(id);
      if (k == 1) begin
        n_cmp++; if ({o_acc, o_rej} !== 2'b00) begin n_err++; $display("FAIL pulse_width id%0d: got acc/rej=%b want 00", id, {o_acc, o_rej}); end
      end
      if (k < endk) begin
        n_cmp++; if ({o_rdy, o_win} !== 9'd0) begin n_err++; $display("FAIL scan_busy id%0d E%0d: got rdy=%b win=%0d want 0 0", id, k, o_rdy, o_win); end
      end else begin
        if (wd >= 0) begin mwin[id] = mturn[id] + 1; mover[id] = 1'b1; end
        else if (mcnt[id] == n) begin mdraw[id] = 1'b1; mover[id] = 1'b1; end
        else mturn[id] = (mturn[id] + 1) % p_pl(id);
        n_cmp++; if (o_win !== 8'(mwin[id])) begin n_err++; $display("FAIL winner id%0d E%0d: got %0d want %0d", id, k, o_win, mwin[id]); end
        n_cmp++; if ({o_draw, o_over} !== {mdraw[id], mover[id]}) begin n_err++; $display("FAIL draw_over id%0d: got %b%b want %b%b", id, o_draw, o_over, mdraw[id], mover[id]); end
        n_cmp++; if (o_rdy !== !mover[id]) begin n_err++; $display("FAIL ready_after id%0d: got %b want %b", id, o_rdy, !mover[id]); end
        n_cmp++; if (o_turn !== 8'(mturn[id])) begin n_err++; $display("FAIL turn id%0d: got %0d want %0d", id, o_turn, mturn[id]); end
        n_cmp++; if (o_cnt !== 8'(mcnt[id])) begin n_err++; $display("FAIL count id%0d: got %0d want %0d", id, o_cnt, mcnt[id]); end
        n_cmp++; if (o_board !== exp_board(id)) begin n_err++; $display("FAIL board id%0d: got %h want %h", id, o_board, exp_board(id)); end
      end
    end
  endtask

  task automatic do_clear(input int id, input bit with_mv);
    @(negedge clk);
    set_clr(id, 1'b1);
    if (with_mv) set_mv(id, 1'b1, 0);
    @(posedge clk); @(negedge clk);
    set_clr(id, 1'b0); set_mv(id, 1'b0, 0);
    for (int i = 0; i < 20; i++) mb[id][i] = 0;
    mfirst[id] = (mfirst[id] + 1) % p_pl(id);
    mturn[id] = mfirst[id];
    mcnt[id] = 0; mwin[id] = 0; mdraw[id] = 1'b0; mover[id] = 1'b0;
    snap(id);
    n_cmp++; if (o_board !== 64'd0) begin n_err++; $display("FAIL clear_board id%0d: got %h want 0", id, o_board); end
    n_cmp++; if ({o_cnt, o_win, o_draw, o_over} !== 18'd0) begin n_err++; $display("FAIL clear_flags id%0d: got cnt=%0d win=%0d draw=%b over=%b want 0", id, o_cnt, o_win, o_draw, o_over); end
    n_cmp++; if (o_turn !== 8'(mturn[id])) begin n_err++; $display("FAIL clear_turn id%0d: got %0d want %0d", id, o_turn, mturn[id]); end
    n_cmp++; if ({o_rdy, o_acc, o_rej} !== 3'b100) begin n_err++; $display("FAIL clear_hs id%0d: got rdy/acc/rej=%b want 100", id, {o_rdy, o_acc, o_rej}); end
  endtask

  task automatic test_row_win();
    int seq [5];
    seq = '{0, 3, 1, 4, 2};
    foreach (seq[i]) do_move(0, seq[i]);
    n_cmp++; if (o_win !== 8'd1) begin n_err++; $display("FAIL row_win: got %0d want 1", o_win); end
    do_move(0, 5);
  endtask

  task automatic test_illegal();
    do_clear(0, 1'b0);
    do_move(0, 0);
    do_move(0, 0);
    do_move(0, 9);
    do_move(0, 15);
  endtask

  task automatic test_anti_and_wrap();
    int a [5];
    int w [5];
    a = '{2, 0, 4, 1, 6};
    w = '{2, 0, 3, 8, 4};
    do_clear(0, 1'b0);
    foreach (a[i]) do_move(0, a[i]);
    do_clear(0, 1'b0);
    foreach (w[i]) do_move(0, w[i]);
    n_cmp++; if (o_over !== 1'b0) begin n_err++; $display("FAIL no_wrap: got over=%b want 0", o_over); end
  endtask

  task automatic test_draw();
    int s [9];
    s = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    do_clear(0, 1'b0);
    foreach (s[i]) do_move(0, s[i]);
  endtask

  task automatic test_clear_mid();
    test_reset();
    @(negedge clk); set_mv(0, 1'b1, 4);
    @(posedge clk); @(negedge clk);
    snap(0);
    n_cmp++; if (o_acc !== 1'b1) begin n_err++; $display("FAIL mid_accept: got %b want 1", o_acc); end
    do_clear(0, 1'b1);
    do_clear(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_move(0, 4); do_move(1, 7); do_move(1, 8);
    test_reset();
  endtask

  task automatic test_sweep();
    int v [12];
    int t [4];
    int pick;
    v = '{0, 1, 2, 4, 3, 7, 10, 11, 12, 19, 18, 17};
    t = '{0, 0, 2, 1};
    foreach (v[i]) do_move(1, v[i]);
    test_reset();
    for (int m = 0; m < 20; m++) begin
      pick = -1;
      for (int i = 19; i >= 0; i--) begin
        if (mb[1][i] == 0 && ((i % 5) + t[i / 5]) % 3 == mturn[1]) pick = i;
      end
      if (pick < 0) pick = 0;
      do_move(1, pick);
    end
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL sweep_draw: got %b want 1", o_draw); end
  endtask

  task automatic test_random(input int id, input int games);
    int n, loc;
    int fr [$];
    n = p_rows(id) * p_cols(id);
    for (int g = 0; g < games; g++) begin
      for (int tr = 0; tr < 80 && !mover[id]; tr++) begin
        if ($urandom_range(0, 4) == 0) loc = int'($urandom_range(0, (id == 0) ? 15 : 31));
        else begin
          fr.delete();
          for (int i = 0; i < n; i++) if (mb[id][i] == 0) fr.push_back(i);
          loc = fr[$urandom_range(0, fr.size() - 1)];
        end
        do_move(id, loc);
      end
      do_move(id, int'($urandom_range(0, n - 1)));
      do_clear(id, 1'(int'($urandom_range(0, 1))));
    end
  endtask

  initial begin
    set_mv(0, 1'b0, 0);
    set_mv(1, 1'b0, 0);
    test_reset();
    test_row_win();
    test_illegal();
    test_anti_and_wrap();
    test_draw();
    test_clear_mid();
    test_reset_mid();
    test_sweep();
    test_random(0, 8);
    test_random(1, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
